taillight_ctrl: RTL
===================

// Module: taillight_ctrl
// PURPOSE
//  Front-end sequencer for the taillight datapath. Sits between the raw board switches (haz/left/right) and the taillight FSM.
//  Synchronises and debounces the switches and arbitrates them into a single active mode. Generates the blink tick as a
//  one-cycle enable rather than a divided clock. Mode changes are committed only at sequence boundaries, so a sequence
//  that has started always runs to completion.
// PARAMETERS
//  DIV_CNT     8333333  system clocks per blink tick (50 MHz -> 6 Hz); must be >= 2
//  DEB_CYCLES  500000   consecutive stable clocks needed before a debounced input changes; must be >= 1
//  LR_PHASES   4        phases per left/right sequence (phase 0 = all off, 1..3 = lamps 1..3)
//  HZ_PHASES   2        phases per hazard sequence (phase 0 = all off, 1 = all on)
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  synchronous reset, active low
//  haz_in     in   1  raw hazard switch (asynchronous to clk)
//  left_in    in   1  raw left switch (asynchronous to clk)
//  right_in   in   1  raw right switch (asynchronous to clk)
//  tick       out  1  one-clock pulse, once every DIV_CNT clocks
//  haz_cmd    out  1  hazard mode active
//  left_cmd   out  1  left mode active
//  right_cmd  out  1  right mode active
//  phase      out  2  current phase within the sequence
//  busy       out  1  a sequence is in progress (mode != IDLE)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - all outputs 0; synchronisers, debounce counters and debounced values 0
//   - divider count 0; state IDLE
//  Sync:
//   - each raw input passes through a 2-FF synchroniser
//  Debounce (per input):
//   - counter increments while the synced value != debounced value; it clears when they are equal
//   - when the counter reaches DEB_CYCLES, the debounced value takes the synced value and the counter clears
//  Divider:
//   - cnt runs 0..DIV_CNT-1 and wraps
//   - tick=1 for exactly the cycle in which cnt==DIV_CNT-1
//   - the first tick after reset falls on clock DIV_CNT
//  Arbitration (combinational, on debounced values):
//   - haz, or left & right both asserted -> HAZ
//   - else left -> LEFT
//   - else right -> RIGHT
//   - else IDLE
//  FSM states: IDLE, LEFT, RIGHT, HAZ. Nothing changes except on a cycle with tick=1.
//   - IDLE & tick: state <= arbitrated request; phase <= 0
//   - LEFT/RIGHT & tick: if phase==LR_PHASES-1, state <= request and phase <= 0; else phase <= phase+1
//   - HAZ & tick: if phase==HZ_PHASES-1, state <= request and phase <= 0; else phase <= phase+1
//   - if the request drops or changes mid-sequence, it is ignored until the boundary
//     (a held request restarts at phase 0)
//   - exception: a new HAZ request while in LEFT/RIGHT preempts at the next tick (state <= HAZ, phase <= 0)
//  Outputs:
//   - registered; cmds are one-hot or all-zero, decoded from state
//   - busy = (state != IDLE)
//   - phase and cmds update in the same clock as the tick, so they are valid from the cycle after tick
//  Latency, raw edge to cmd: 2 (sync) + DEB_CYCLES + wait for the next eligible tick + 1
//  Glitch: a pulse shorter than DEB_CYCLES never changes the debounced value
//  Reset mid-sequence: immediate return to IDLE with phase 0; the divider restarts
// TESTING (DIV_CNT=4, DEB_CYCLES=3)
//  1. Reset held, toggle all inputs -> all outputs 0; tick first pulses 4 clocks after rst_n rises.
//  2. left_in=1 held -> left_cmd=1 at the first tick after debounce; phase steps 0,1,2,3,0 on successive ticks.
//  3. left_in=1, then dropped while phase=1 -> phases 2,3 still run; IDLE at the next boundary tick, busy=0.
//  4. left & right held together -> haz_cmd=1; phase alternates 0,1.
//  5. haz_in asserted while in LEFT phase 2 -> haz_cmd=1 and phase 0 at the next tick.
//     Also: a 2-clock glitch on right_in from IDLE -> no cmd change.
//  6. rst_n=0 for 1 clock during RIGHT phase 2 -> next cycle all outputs 0 and state IDLE;
//     the sequence restarts only after debounce and tick.

Source files
------------

// File: rtl/taillight_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : taillight_ctrl_if
//  Description : Switch inputs and sequencer outputs of the taillight front end.
//  Revision    : 1.0 - initial release
// ============================================================================
interface taillight_ctrl_if;
    logic       haz_in;
    logic       left_in;
    logic       right_in;
    logic       tick;
    logic       haz_cmd;
    logic       left_cmd;
    logic       right_cmd;
    logic [1:0] phase;
    logic       busy;

    modport master (
        output haz_in, left_in, right_in,
        input  tick, haz_cmd, left_cmd, right_cmd, phase, busy
    );

    modport slave (
        input  haz_in, left_in, right_in,
        output tick, haz_cmd, left_cmd, right_cmd, phase, busy
    );
endinterface
`default_nettype wire

// File: rtl/taillight_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : taillight_ctrl
//  Description : Synchronise/debounce the taillight switches, arbitrate a mode
//                and step it through phases on a divided blink tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module taillight_ctrl #(
    parameter int DIV_CNT    = 8333333,
    parameter int DEB_CYCLES = 500000,
    parameter int LR_PHASES  = 4,
    parameter int HZ_PHASES  = 2
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    taillight_ctrl_if.slave     tl
);

    localparam int         c_div_w   = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
    localparam int         c_deb_w   = $clog2(DEB_CYCLES + 1);
    localparam logic [1:0] c_lr_last = 2'(LR_PHASES - 1);
    localparam logic [1:0] c_hz_last = 2'(HZ_PHASES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEFT  = 2'd1,
        S_RIGHT = 2'd2,
        S_HAZ   = 2'd3
    } state_t;

    // Bit order everywhere: [2]=haz, [1]=left, [0]=right
    logic [2:0] w_raw;
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] w_deb;

    assign w_raw = {tl.haz_in, tl.left_in, tl.right_in};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_deb
        logic [c_deb_w-1:0] r_cnt;
        logic               r_val;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt <= '0;
                r_val <= 1'b0;
            end else if (r_sync2[gi] == r_val) begin
                r_cnt <= '0;
            end else if (r_cnt == c_deb_w'(DEB_CYCLES - 1)) begin
                r_val <= r_sync2[gi];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_deb[gi] = r_val;
    end

    // Tick is a decode of the counter, so it is glitch-free and exactly one clock wide
    logic [c_div_w-1:0] r_div;
    logic               w_tick;

    assign w_tick = (r_div == c_div_w'(DIV_CNT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)      r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + 1'b1;
    end

    state_t w_req;

    always_comb begin
        w_req = S_IDLE;
        if (w_deb[2] || (w_deb[1] && w_deb[0])) w_req = S_HAZ;
        else if (w_deb[1])                      w_req = S_LEFT;
        else if (w_deb[0])                      w_req = S_RIGHT;
    end

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_phase;
    logic [1:0] w_next_phase;
    logic       r_haz_cmd;
    logic       r_left_cmd;
    logic       r_right_cmd;
    logic       r_busy;

    always_comb begin
        w_next_state = r_state;
        w_next_phase = r_phase;
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    w_next_state = w_req;
                    w_next_phase = 2'd0;
                end
                S_LEFT, S_RIGHT: begin
                    if (r_phase == c_lr_last || w_req == S_HAZ) begin
                        w_next_state = w_req;
                        w_next_phase = 2'd0;
                    end else begin
                        w_next_phase = r_phase + 2'd1;
                    end
                end
                default: begin
                    if (r_phase == c_hz_last) begin
                        w_next_state = w_req;
                        w_next_phase = 2'd0;
                    end else begin
                        w_next_phase = r_phase + 2'd1;
                    end
                end
            endcase
        end
    end

    // Outputs decode the next state so they line up with state/phase
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_phase     <= 2'd0;
            r_haz_cmd   <= 1'b0;
            r_left_cmd  <= 1'b0;
            r_right_cmd <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_phase     <= w_next_phase;
            r_haz_cmd   <= (w_next_state == S_HAZ);
            r_left_cmd  <= (w_next_state == S_LEFT);
            r_right_cmd <= (w_next_state == S_RIGHT);
            r_busy      <= (w_next_state != S_IDLE);
        end
    end

    assign tl.tick      = w_tick;
    assign tl.haz_cmd   = r_haz_cmd;
    assign tl.left_cmd  = r_left_cmd;
    assign tl.right_cmd = r_right_cmd;
    assign tl.phase     = r_phase;
    assign tl.busy      = r_busy;

endmodule
`default_nettype wire
